// File: rtl/timer_disp_pkg.sv
// Shared types and constants for the timer display stage: conversion FSM
// states and the active-low a..g seven-segment digit table.
package timer_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    // Index = BCD code; codes 10..15 never come out of a valid conversion and show blank.
    localparam logic [0:6] SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern (a..g).
module seg7_decode
    import timer_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/timer_hex_display.sv
// Display stage for the countdown timer: sequential double-dabble conversion
// of each new value into two BCD digits, with a fail-triggered blink sequence.
module timer_hex_display
    import timer_disp_pkg::*;
#(
    parameter int VAL_W        = 6,
    parameter int BLINK_DIV    = 25_000_000,
    parameter int FAIL_TOGGLES = 6,
    parameter bit LZ_BLANK     = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [VAL_W-1:0] value_in,
    input  logic             value_valid,
    input  logic             fail_in,
    output logic [0:6]       hex0,
    output logic [0:6]       hex1,
    output logic             busy,
    output logic             fail_led
);

    localparam int WORK_W  = 8 + VAL_W;
    localparam int BITC_W  = $clog2(VAL_W + 1);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int TOG_W   = $clog2(FAIL_TOGGLES + 1);

    conv_state_t        state, state_nxt;
    logic [VAL_W-1:0]   cap_val, pend_val, start_val;
    logic               pend_vld, start_req;
    logic [WORK_W-1:0]  work;
    logic [BITC_W-1:0]  bit_cnt;
    logic [3:0]         tens, units;
    logic [BLINK_W-1:0] blink_cnt;
    logic [TOG_W-1:0]   toggle_cnt;
    logic               blank;
    logic [0:6]         seg_tens, seg_units;

    function automatic logic [VAL_W-1:0] sat99(input logic [VAL_W-1:0] v);
        if (int'(v) > 99) return VAL_W'(99);
        return v;
    endfunction

    // One double-dabble iteration on {bcd[7:0], binary}: correct nibbles >= 5, then shift.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] t;
        t = w;
        if (t[WORK_W-1 -: 4] >= 4'd5) t[WORK_W-1 -: 4] = t[WORK_W-1 -: 4] + 4'd3;
        if (t[WORK_W-5 -: 4] >= 4'd5) t[WORK_W-5 -: 4] = t[WORK_W-5 -: 4] + 4'd3;
        return {t[WORK_W-2:0], 1'b0};
    endfunction

    // A fresh strobe outranks a parked value: last write wins.
    assign start_req = value_valid || pend_vld;
    assign start_val = value_valid ? sat99(value_in) : pend_val;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start_req) state_nxt = ST_LOAD;
            ST_LOAD:   state_nxt = ST_SHIFT;
            ST_SHIFT:  if (bit_cnt == BITC_W'(1)) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = start_req ? ST_LOAD : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_vld <= 1'b0;
            tens     <= 4'd0;
            units    <= 4'd0;
        end else begin
            if (state == ST_LOAD || state == ST_SHIFT) begin
                if (value_valid) pend_vld <= 1'b1;
            end else if (start_req) begin
                pend_vld <= 1'b0;
            end
            if (state == ST_COMMIT) begin
                tens  <= work[WORK_W-1 -: 4];
                units <= work[WORK_W-5 -: 4];
            end
        end
    end

    // Conversion datapath; contents are don't-care until LOAD initialises them.
    always_ff @(posedge clk) begin
        if ((state == ST_LOAD || state == ST_SHIFT) && value_valid) pend_val <= sat99(value_in);
        unique case (state)
            ST_IDLE, ST_COMMIT: if (start_req) cap_val <= start_val;
            ST_LOAD: begin
                work    <= {8'd0, cap_val};
                bit_cnt <= BITC_W'(VAL_W);
            end
            ST_SHIFT: begin
                work    <= dabble_step(work);
                bit_cnt <= bit_cnt - BITC_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fail_led   <= 1'b0;
            blank      <= 1'b0;
            blink_cnt  <= '0;
            toggle_cnt <= '0;
        end else if (fail_in) begin
            fail_led   <= 1'b1;
            blank      <= 1'b1;
            blink_cnt  <= '0;
            toggle_cnt <= '0;
        end else if (fail_led) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt  <= '0;
                toggle_cnt <= toggle_cnt + TOG_W'(1);
                if (toggle_cnt == TOG_W'(FAIL_TOGGLES - 1)) begin
                    fail_led <= 1'b0;
                    blank    <= 1'b0;
                end else begin
                    blank <= ~blank;
                end
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign busy = (state != ST_IDLE);

    seg7_decode u_seg_units (.digit(units), .seg(seg_units));
    seg7_decode u_seg_tens  (.digit(tens),  .seg(seg_tens));

    assign hex0 = blank ? SEG_BLANK : seg_units;
    assign hex1 = (blank || (LZ_BLANK && tens == 4'd0)) ? SEG_BLANK : seg_tens;

endmodule

// File: tb/tb_timer_hex_display.sv
// Bench for timer_hex_display: directed scenarios plus random traffic, all
// checked every cycle against a countdown-style behavioural model.
module tb_timer_hex_display;

    localparam int VAL_W        = 6;
    localparam int BLINK_DIV    = 4;
    localparam int FAIL_TOGGLES = 6;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             value_valid = 1'b0;
    logic             fail_in = 1'b0;
    logic [VAL_W-1:0] value_in = '0;
    logic [0:6]       hex0, hex1, hex0_lz, hex1_lz;
    logic             busy, fail_led, busy_lz, fail_led_lz;

    int checks = 0;
    int errors = 0;

    timer_hex_display #(.VAL_W(VAL_W), .BLINK_DIV(BLINK_DIV), .FAIL_TOGGLES(FAIL_TOGGLES),
                        .LZ_BLANK(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_valid(value_valid),
        .fail_in(fail_in), .hex0(hex0), .hex1(hex1), .busy(busy), .fail_led(fail_led));

    timer_hex_display #(.VAL_W(VAL_W), .BLINK_DIV(BLINK_DIV), .FAIL_TOGGLES(FAIL_TOGGLES),
                        .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .reset_n(reset_n), .value_in(value_in), .value_valid(value_valid),
        .fail_in(fail_in), .hex0(hex0_lz), .hex1(hex1_lz), .busy(busy_lz), .fail_led(fail_led_lz));

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;
            2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;
            6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a conversion is a countdown of VAL_W+2 busy cycles ending in a
    // commit; the blink is an age counter since the last fail pulse.
    bit model_ok = 0;
    int m_shown, m_cv, m_rem, m_pv, m_t;
    bit m_act, m_pend, m_on;

    always @(posedge clk) begin
        if (!reset_n) begin
            model_ok = 1;
            m_shown = 0; m_act = 0; m_rem = 0; m_pend = 0; m_on = 0; m_t = 0;
        end else begin
            if (value_valid) begin
                m_pend = 1;
                m_pv   = (int'(value_in) > 99) ? 99 : int'(value_in);
            end
            if (m_act) begin
                if (m_rem == 1) begin
                    m_shown = m_cv;
                    m_act   = 0;
                end else begin
                    m_rem--;
                end
            end
            if (!m_act && m_pend) begin
                m_act  = 1;
                m_rem  = VAL_W + 2;
                m_cv   = m_pv;
                m_pend = 0;
            end
            if (fail_in) begin
                m_on = 1;
                m_t  = 0;
            end else if (m_on) begin
                m_t++;
                if (m_t == BLINK_DIV * FAIL_TOGGLES) m_on = 0;
            end
        end
    end

    bit saw37 = 0;
    bit saw42 = 0;

    always @(negedge clk) begin
        logic       blank;
        logic [6:0] e0, e1, e1lz;
        if (model_ok) begin
            blank = m_on && (((m_t / BLINK_DIV) % 2) == 0);
            e0    = blank ? 7'h7F : seg_ref(m_shown % 10);
            e1    = blank ? 7'h7F : seg_ref(m_shown / 10);
            e1lz  = (blank || (m_shown / 10) == 0) ? 7'h7F : e1;
            chk("hex0", 32'(hex0), 32'(e0));
            chk("hex1", 32'(hex1), 32'(e1));
            chk("busy", 32'(busy), 32'(m_act));
            chk("fail_led", 32'(fail_led), 32'(m_on));
            chk("hex0_lz", 32'(hex0_lz), 32'(e0));
            chk("hex1_lz", 32'(hex1_lz), 32'(e1lz));
            chk("busy_lz", 32'(busy_lz), 32'(m_act));
            if (7'(hex1) == seg_ref(3) && 7'(hex0) == seg_ref(7)) saw37 = 1;
            if (7'(hex1) == seg_ref(4) && 7'(hex0) == seg_ref(2)) saw42 = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic strobe(input int v);
        value_in    = VAL_W'(v);
        value_valid = 1'b1;
        step();
        value_valid = 1'b0;
    endtask

    initial begin
        // Reset for two cycles
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        chk("rst_hex0", 32'(hex0), 32'(7'b0000001));
        chk("rst_hex1", 32'(hex1), 32'(7'b0000001));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fail_led", 32'(fail_led), 32'd0);
        chk("rst_hex1_lz", 32'(hex1_lz), 32'(7'b1111111));
        cyc(2);

        // Single conversion of 59: busy N+1..N+8, digits after N+8
        strobe(59);
        chk("t2_busy_n1", 32'(busy), 32'd1);
        cyc(7);
        chk("t2_busy_n8", 32'(busy), 32'd1);
        chk("t2_old_hex0", 32'(hex0), 32'(7'b0000001));
        cyc(1);
        chk("t2_hex1", 32'(hex1), 32'(7'b0100100));
        chk("t2_hex0", 32'(hex0), 32'(7'b0000100));
        chk("t2_busy_done", 32'(busy), 32'd0);
        cyc(3);

        // 42, then 37 and 36 while busy: 37 is overwritten in the pending slot
        saw37 = 0;
        saw42 = 0;
        strobe(42);
        cyc(2);
        strobe(37);
        cyc(1);
        strobe(36);
        cyc(20);
        chk("t3_saw42", 32'(saw42), 32'd1);
        chk("t3_no37", 32'(saw37), 32'd0);
        chk("t3_hex1", 32'(hex1), 32'(7'b0000110));
        chk("t3_hex0", 32'(hex0), 32'(7'b0100000));

        // Fail blink over a stable "36"
        fail_in = 1'b1;
        step();
        fail_in = 1'b0;
        chk("t4_blank_hex0", 32'(hex0), 32'(7'b1111111));
        chk("t4_blank_hex1", 32'(hex1), 32'(7'b1111111));
        chk("t4_led_on", 32'(fail_led), 32'd1);
        cyc(4);
        chk("t4_show_hex0", 32'(hex0), 32'(7'b0100000));
        cyc(19);
        chk("t4_led_last", 32'(fail_led), 32'd1);
        cyc(1);
        chk("t4_led_off", 32'(fail_led), 32'd0);
        chk("t4_final_hex0", 32'(hex0), 32'(7'b0100000));
        cyc(3);

        // Fail and a new value in the same cycle
        fail_in     = 1'b1;
        value_in    = VAL_W'(59);
        value_valid = 1'b1;
        step();
        fail_in     = 1'b0;
        value_valid = 1'b0;
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_blank", 32'(hex0), 32'(7'b1111111));
        cyc(12);
        chk("t5_hex1", 32'(hex1), 32'(7'b0100100));
        chk("t5_hex0", 32'(hex0), 32'(7'b0000100));
        cyc(15);

        // Reset in the middle of converting 63, then convert 7
        strobe(63);
        cyc(2);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("t6_hex0", 32'(hex0), 32'(7'b0000001));
        chk("t6_hex1", 32'(hex1), 32'(7'b0000001));
        chk("t6_busy", 32'(busy), 32'd0);
        strobe(7);
        cyc(9);
        chk("t6_hex0_7", 32'(hex0), 32'(7'b0001111));
        chk("t6_hex1_0", 32'(hex1), 32'(7'b0000001));
        chk("t6_hex1_lz", 32'(hex1_lz), 32'(7'b1111111));
        chk("t6_hex0_lz", 32'(hex0_lz), 32'(7'b0001111));

        // Random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 499) != 0);
            value_valid = ($urandom_range(0, 7) == 0);
            value_in    = VAL_W'($urandom);
            fail_in     = ($urandom_range(0, 63) == 0);
            step();
        end
        reset_n     = 1'b1;
        value_valid = 1'b0;
        fail_in     = 1'b0;
        cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
